mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 16-bit pipelined core; sits directly downstream of the execute-stage ALU.
- Consumes the ALU result as a load/store address or as pass-through data.
- Runs a variable-latency request/done handshake to data memory and stalls upstream while a request is outstanding.
- Registers the outcome toward writeback and provides a same-cycle forwarding tap back to execute.

Parameters:
TIMEOUT, 15, cycles to wait for mem_done before aborting with an error; 0 disables the timeout
REG_W, 3, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  execute-stage result present
in_ready  out  1  stage can accept this cycle (a low value stalls execute)
alu_res  in  16  ALU output: address for load/store, else writeback data
st_data  in  16  store data (Rt)
mem_rd  in  1  instruction is a load
mem_wr  in  1  instruction is a store
reg_wr  in  1  instruction writes a register
wr_reg  in  REG_W  destination register
halt  in  1  instruction is HALT
mem_req  out  1  memory request, held until done
mem_we  out  1  request is a write
mem_addr  out  16  request address
mem_wdata  out  16  store data
mem_rdata  in  16  load data, valid with mem_done
mem_done  in  1  memory completes the request this cycle
wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction)
wb_reg_wr  out  1  register write enable
wb_reg  out  REG_W  destination register
wb_data  out  16  writeback value
wb_halt  out  1  retiring HALT
wb_err  out  1  misaligned access or timeout
fwd_valid  out  1  = wb_valid & wb_reg_wr
fwd_reg  out  REG_W  = wb_reg
fwd_data  out  16  = wb_data

Behaviour:
- Reset: state IDLE, halted=0, timeout counter=0. All wb_*, mem_req, mem_we, mem_addr and mem_wdata are 0. in_ready=1 the cycle after rst deasserts.
- in_ready = (state==IDLE) & ~halted. An instruction is accepted on an edge where in_valid & in_ready.
- State IDLE, accepted non-memory instruction (mem_rd=mem_wr=0):
  - Next edge: wb_valid=1, wb_data=alu_res, wb_reg_wr=reg_wr, wb_reg=wr_reg, wb_halt=halt.
  - Latency 1; throughput 1 per cycle.
- State IDLE, accepted memory instruction, misaligned (alu_res[0]=1):
  - No request is issued.
  - Next edge: wb_valid=1, wb_err=1, wb_reg_wr=0, wb_data=alu_res.
- State IDLE, accepted aligned memory instruction:
  - Capture fields. Go to ACCESS. Drive mem_req=1, mem_we=mem_wr, mem_addr=alu_res, mem_wdata=st_data (registered, stable for the whole ACCESS).
  - wb_valid=0 during ACCESS.
- State ACCESS:
  - Counter increments each cycle.
  - On the edge where mem_done=1: state returns to IDLE; mem_req and mem_we drop to 0; wb_valid=1; wb_reg_wr=captured reg_wr & ~store; wb_data=mem_rdata for a load, captured alu_res for a store.
  - A completion that arrives in the first ACCESS cycle gives a total latency of 2.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without mem_done: return to IDLE, mem_req=0, wb_valid=1, wb_err=1, wb_reg_wr=0.
- mem_done while mem_req=0 is ignored.
- mem_done and timeout in the same cycle: the completion wins and wb_err=0.
- Simultaneous completion and in_valid: in_ready is 0 in ACCESS, so the new instruction is accepted on the following cycle.
- Halt: after an instruction with halt=1 retires (wb_valid & wb_halt), halted=1 and in_ready stays 0 until reset.
- Memory ops are still completed when halt is set on the same instruction.
- wb_* fields other than wb_valid hold their last value when wb_valid=0. wb_err is cleared on every wb_valid pulse that is not an error.
- Reset mid-ACCESS: the request is abandoned and mem_req=0 on the next edge. A late mem_done is ignored. No writeback occurs.
- All arithmetic is 16-bit. The timeout counter is 5-bit and saturates.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ACCESS);
  - TIMEOUT default;
  - REG_W;
  - the writeback bundle field widths shared with the writeback stage and the forwarding mux in execute.
- One sub-module, mem_timeout_ctr: clear on accept, increment in ACCESS, expired output.

Test Plan:
- ADD result alu_res=0x1234, reg_wr=1, wr_reg=3 → one cycle later wb_valid=1, wb_data=0x1234, wb_reg=3, fwd_valid=1; in_ready stays 1.
- Load with alu_res=0x0040, mem_done after 3 ACCESS cycles with mem_rdata=0xBEEF → mem_req high exactly 3 cycles, mem_addr=0x0040, mem_we=0, in_ready low throughout; then wb_data=0xBEEF, wb_reg_wr=1.
- Store with alu_res=0x0010, st_data=0x00FF, done after 1 cycle → mem_we=1, mem_wdata=0x00FF; wb_valid=1, wb_reg_wr=0, wb_err=0.
- Load with alu_res=0x0041 → no mem_req; next cycle wb_valid=1, wb_err=1, wb_reg_wr=0.
- Load with mem_done never asserted, TIMEOUT=15 → mem_req high 15 cycles, then wb_err=1 and in_ready=1; a mem_done on cycle 17 is ignored.
- rst asserted on the 2nd ACCESS cycle → mem_req=0 next cycle, no wb_valid pulse; a following HALT retires with wb_halt=1, after which in_ready=0 despite in_valid=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, default parameters,
// and the writeback bundle widths that writeback and execute forwarding also use.
package mem_stage_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int REG_W_DEFAULT   = 3;
  localparam int DATA_W          = 16;
  localparam int CNT_W           = 5;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating access-cycle counter; flags the ACCESS cycle whose increment
// would bring the count up to TIMEOUT (TIMEOUT of 0 never expires).
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && inc_i && ((int'(cnt_q) + 1) >= TIMEOUT);
endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, or runs a request/done access to
// data memory while stalling execute, then registers the writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int REG_W   = REG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] st_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              reg_wr,
  input  logic [REG_W-1:0]  wr_reg,
  input  logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              wb_valid,
  output logic              wb_reg_wr,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_halt,
  output logic              wb_err,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);
  state_e            state_q;
  logic              halted_q;
  logic              mem_req_q, mem_we_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic              cap_reg_wr_q, cap_halt_q;
  logic [REG_W-1:0]  cap_reg_q;
  logic              wb_valid_q, wb_reg_wr_q, wb_halt_q, wb_err_q;
  logic [REG_W-1:0]  wb_reg_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              accept, is_mem, expired;

  assign in_ready = (state_q == IDLE) && !halted_q;
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_rd || mem_wr;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .inc_i    (state_q == ACCESS),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      halted_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cap_reg_wr_q <= 1'b0;
      cap_halt_q   <= 1'b0;
      cap_reg_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_wr_q  <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      wb_halt_q    <= 1'b0;
      wb_err_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_mem || alu_res[0]) begin
              // pass-through or misaligned access: retire next edge, no request
              wb_valid_q  <= 1'b1;
              wb_data_q   <= alu_res;
              wb_reg_q    <= wr_reg;
              wb_halt_q   <= halt;
              wb_reg_wr_q <= is_mem ? 1'b0 : reg_wr;
              wb_err_q    <= is_mem;
              if (halt) halted_q <= 1'b1;
            end else begin
              state_q      <= ACCESS;
              mem_req_q    <= 1'b1;
              mem_we_q     <= mem_wr;
              mem_addr_q   <= alu_res;
              mem_wdata_q  <= st_data;
              cap_reg_wr_q <= reg_wr;
              cap_reg_q    <= wr_reg;
              cap_halt_q   <= halt;
            end
          end
        end
        ACCESS: begin
          // completion takes priority over a coincident timeout
          if (mem_done || expired) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            wb_valid_q  <= 1'b1;
            wb_reg_q    <= cap_reg_q;
            wb_halt_q   <= cap_halt_q;
            wb_err_q    <= !mem_done;
            wb_reg_wr_q <= mem_done && cap_reg_wr_q && !mem_we_q;
            wb_data_q   <= (mem_done && !mem_we_q) ? mem_rdata : mem_addr_q;
            if (cap_halt_q) halted_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_reg_wr = wb_reg_wr_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign wb_halt   = wb_halt_q;
  assign wb_err    = wb_err_q;
  assign fwd_valid = wb_valid_q && wb_reg_wr_q;
  assign fwd_reg   = wb_reg_q;
  assign fwd_data  = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, then random traffic with a
// memory responder of chosen latency; a monitor checks every writeback.
module tb_mem_stage;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_res = '0, st_data = '0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, reg_wr = 1'b0, halt = 1'b0;
  logic [2:0]  wr_reg = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        wb_valid, wb_reg_wr, wb_halt, wb_err, fwd_valid;
  logic [2:0]  wb_reg, fwd_reg;
  logic [15:0] wb_data, fwd_data;

  mem_stage #(.TIMEOUT(TMO), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .st_data(st_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_wr(reg_wr), .wr_reg(wr_reg), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_halt(wb_halt), .wb_err(wb_err),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reg_wr;
    logic [2:0]  rg;
    logic [15:0] data;
    logic        halt;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: outcome of one instruction from its fields and the cycle (1-based
  // within the access) at which memory answers; lat 0 means memory never answers.
  function automatic exp_t model(input logic [15:0] alu, input logic rd, input logic wr,
                                 input logic rw, input logic [2:0] rg, input logic h,
                                 input int lat, input logic [15:0] rdata);
    exp_t e;
    e.rg = rg; e.halt = h; e.chk_data = 1'b1;
    if (!(rd || wr)) begin
      e.reg_wr = rw; e.data = alu; e.err = 1'b0;
    end else if (alu[0]) begin
      e.reg_wr = 1'b0; e.data = alu; e.err = 1'b1;
    end else if (lat >= 1 && lat <= TMO) begin
      e.reg_wr = rw && !wr; e.data = wr ? alu : rdata; e.err = 1'b0;
    end else begin
      e.reg_wr = 1'b0; e.data = alu; e.err = 1'b1; e.chk_data = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [15:0] alu, input logic [15:0] st, input logic rd,
                       input logic wr, input logic rw, input logic [2:0] rg,
                       input logic h, input int lat, input logic [15:0] rdata);
    int  w;
    logic bus_ok;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    exp_q.push_back(model(alu, rd, wr, rw, rg, h, lat, rdata));
    in_valid = 1'b1; alu_res = alu; st_data = st; mem_rd = rd; mem_wr = wr;
    reg_wr = rw; wr_reg = rg; halt = h;
    mem_done = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_done = 1'b0; halt = 1'b0;
    if (!(rd || wr) || alu[0]) begin
      chk("lat1_wb_valid", 32'(wb_valid), 32'd1);
      chk("no_mem_req", 32'(mem_req), 32'd0);
    end else begin
      bus_ok = 1'b1;
      for (int k = 1; k <= TMO; k++) begin
        bus_ok &= (mem_req === 1'b1) && (mem_we === wr) && (mem_addr === alu) &&
                  (mem_wdata === st) && (in_ready === 1'b0) && (wb_valid === 1'b0);
        if (k == lat) begin
          mem_done = 1'b1; mem_rdata = rdata;
        end
        @(posedge clk); #1;
        mem_done = 1'b0;
        if (k == lat) break;
      end
      chk("access_bus", 32'(bus_ok), 32'd1);
      chk("done_wb_valid", 32'(wb_valid), 32'd1);
      chk("req_dropped", 32'(mem_req), 32'd0);
      chk("in_ready_after", 32'(in_ready), 32'(!h));
    end
  endtask

  // Monitor: pop one expectation per writeback pulse; outside pulses wb_data must hold.
  logic [15:0] last_data = '0;
  logic        hold_known = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_data = '0; hold_known = 1'b1;
    end else if (wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wb actual wb_valid=1 data=0x%0h required=no writeback", wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_err", 32'(wb_err), 32'(e.err));
        chk("wb_reg_wr", 32'(wb_reg_wr), 32'(e.reg_wr));
        chk("fwd_valid", 32'(fwd_valid), 32'(e.reg_wr));
        if (e.chk_data) begin
          chk("wb_data", 32'(wb_data), 32'(e.data));
          chk("fwd_data", 32'(fwd_data), 32'(e.data));
        end
        if (!e.err) begin
          chk("wb_reg", 32'(wb_reg), 32'(e.rg));
          chk("fwd_reg", 32'(fwd_reg), 32'(e.rg));
          chk("wb_halt", 32'(wb_halt), 32'(e.halt));
        end
        last_data = e.data; hold_known = e.chk_data;
      end
    end else if (hold_known) begin
      chk("wb_hold", 32'(wb_data), 32'(last_data));
    end
  end

  initial begin
    int kind, lat, gap;
    logic [15:0] a, s, rd_v;
    logic wr_b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_bus", {mem_we, 15'd0, mem_addr | mem_wdata}, 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_flags", {29'd0, wb_err, wb_halt, wb_reg_wr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    issue(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 0, 16'h0);
    chk("add_in_ready", 32'(in_ready), 32'd1);
    issue(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3, 16'hBEEF);
    issue(16'h0010, 16'h00FF, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1, 16'h0);
    issue(16'h0041, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1, 16'h0);
    issue(16'h0080, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 0, 16'h0);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1; mem_done = 1'b0;
    issue(16'h0082, 16'h0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, TMO, 16'hC0DE);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      a = 16'($urandom); s = 16'($urandom); rd_v = 16'($urandom);
      wr_b = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: lat = 0;
        1: lat = TMO;
        2: lat = TMO + 1;
        default: lat = $urandom_range(1, 4);
      endcase
      if (kind < 5)
        issue(a, s, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 1'b0, lat, rd_v);
      else if (kind == 5)
        issue(a | 16'h1, s, !wr_b, wr_b, 1'b1, 3'($urandom), 1'b0, lat, rd_v);
      else
        issue(a & 16'hFFFE, s, !wr_b, wr_b, 1'($urandom_range(0, 1)), 3'($urandom), 1'b0, lat, rd_v);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        mem_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      mem_done = 1'b0;
    end

    // reset during the second access cycle abandons the request
    in_valid = 1'b1; alu_res = 16'h0020; mem_rd = 1'b1; mem_wr = 1'b0; reg_wr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid), 32'd0);
    mem_done = 1'b1; mem_rdata = 16'h5555;
    @(posedge clk); #1;
    mem_done = 1'b0;
    chk("late_done_wb", 32'(wb_valid), 32'd0);

    issue(16'h0777, 16'h0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 0, 16'h0);
    in_valid = 1'b1; mem_rd = 1'b0; halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("halted_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
